n64_vbus_demux: RTL and testbench



---
 rtl/n64_vbus_demux.sv | 171 +++++++++++++++++
 tb/tb_n64_vbus_demux.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/n64_vbus_demux.sv
// n64_vbus_demux: front-end receiver for the N64 multiplexed video bus.
// Demultiplexes the 4-phase nDSYNC/D bus into a parallel {S, R, G, B} word
// with a one-cycle valid strobe. It also derives per-field video info
// {FrameID, PAL, interlaced} from the sync edges.
// Optional build macro: VBUS_DEMUX_PHASE_ERR_EN adds the phase_err_o sticky flag.
module n64_vbus_demux #(
  parameter int color_width     = 7,
  parameter int PAL_LINE_THRESH = 288,
  parameter int LCNT_WIDTH      = 10
) (
  input  logic                         VCLK,
  input  logic                         nRST,
  input  logic                         nDSYNC,
  input  logic [color_width-1:0]       D_i,
  output logic [3*color_width+3:0]     vdata_o,
  output logic                         vdata_valid_o,
  output logic [2:0]                   vinfo_o
`ifdef VBUS_DEMUX_PHASE_ERR_EN
  ,
  output logic                         phase_err_o
`endif
);

  localparam logic [LCNT_WIDTH-1:0] LCNT_MAX   = {LCNT_WIDTH{1'b1}};
  localparam logic [LCNT_WIDTH-1:0] PAL_THRESH = LCNT_WIDTH'(PAL_LINE_THRESH);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_R    = 2'd1,
    ST_G    = 2'd2,
    ST_B    = 2'd3
  } phase_t;

  phase_t phase_reg, phase_next;

  // Capture enables decoded from the current phase and nDSYNC
  logic cap_s, cap_r, cap_g, cap_b, resync_err;

  logic [3:0]             s_pre_reg;
  logic [color_width-1:0] r_pre_reg, g_pre_reg, b_pre_reg;
  logic                   b_done_reg;
  logic [3*color_width+3:0] vdata_reg;
  logic                   valid_reg;

  logic                   sync_cap_reg;
  logic [3:0]             s_prev_reg;
  logic [LCNT_WIDTH-1:0]  lcnt_reg;
  logic                   frame_id_reg, pal_reg, interlaced_reg;

  // Falling edges of nHSYNC / nVSYNC between consecutive sync words
  logic hs_fall, vs_fall;

  // Phase state register
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) phase_reg <= ST_SYNC;
    else       phase_reg <= phase_next;
  end

  // Next phase: a low nDSYNC always restarts a pixel, otherwise walk S->R->G->B
  always_comb begin
    phase_next = phase_reg;
    if (!nDSYNC) begin
      phase_next = ST_R;
    end else begin
      case (phase_reg)
        ST_SYNC: phase_next = ST_SYNC;
        ST_R:    phase_next = ST_G;
        ST_G:    phase_next = ST_B;
        ST_B:    phase_next = ST_SYNC;
        default: phase_next = ST_SYNC;
      endcase
    end
  end

  // Phase outputs: which pre-register to load this cycle
  always_comb begin
    cap_s      = !nDSYNC;
    cap_r      = nDSYNC && (phase_reg == ST_R);
    cap_g      = nDSYNC && (phase_reg == ST_G);
    cap_b      = nDSYNC && (phase_reg == ST_B);
    resync_err = !nDSYNC && ((phase_reg == ST_G) || (phase_reg == ST_B));
  end

  // Pre-registers collecting one pixel; b_done marks a completed B phase
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      s_pre_reg  <= 4'hF;
      r_pre_reg  <= '0;
      g_pre_reg  <= '0;
      b_pre_reg  <= '0;
      b_done_reg <= 1'b0;
    end else begin
      if (cap_s) s_pre_reg <= D_i[3:0];
      if (cap_r) r_pre_reg <= D_i;
      if (cap_g) g_pre_reg <= D_i;
      if (cap_b) b_pre_reg <= D_i;
      b_done_reg <= cap_b;
    end
  end

  // Parallel output word, updated and strobed one cycle after the B sample
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      vdata_reg <= {4'hF, {(3*color_width){1'b0}}};
      valid_reg <= 1'b0;
    end else begin
      if (b_done_reg) vdata_reg <= {s_pre_reg, r_pre_reg, g_pre_reg, b_pre_reg};
      valid_reg <= b_done_reg;
    end
  end

  // Edges are only judged on freshly captured sync words, never on colour data
  always_comb begin
    hs_fall = sync_cap_reg && s_prev_reg[1] && !s_pre_reg[1];
    vs_fall = sync_cap_reg && s_prev_reg[3] && !s_pre_reg[3];
  end

  // Line counting and per-field info, evaluated the cycle after a sync capture
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      sync_cap_reg   <= 1'b0;
      s_prev_reg     <= 4'hF;
      lcnt_reg       <= '0;
      frame_id_reg   <= 1'b0;
      pal_reg        <= 1'b0;
      interlaced_reg <= 1'b0;
    end else begin
      sync_cap_reg <= cap_s;
      if (sync_cap_reg) s_prev_reg <= s_pre_reg;
      if (vs_fall) begin
        // An HSYNC edge coinciding with VSYNC marks the odd field and is not a line
        frame_id_reg   <= hs_fall;
        interlaced_reg <= (hs_fall != frame_id_reg);
        pal_reg        <= (lcnt_reg >= PAL_THRESH);
        lcnt_reg       <= '0;
      end else if (hs_fall && (lcnt_reg != LCNT_MAX)) begin
        lcnt_reg <= lcnt_reg + 1'b1;
      end
    end
  end

`ifdef VBUS_DEMUX_PHASE_ERR_EN
  logic       phase_err_reg;
  logic [3:0] good_cnt_reg;

  // Sticky resync error, released after 16 consecutive complete pixels
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      phase_err_reg <= 1'b0;
      good_cnt_reg  <= 4'd0;
    end else if (resync_err) begin
      phase_err_reg <= 1'b1;
      good_cnt_reg  <= 4'd0;
    end else if (b_done_reg) begin
      if (good_cnt_reg == 4'hF) begin
        phase_err_reg <= 1'b0;
        good_cnt_reg  <= 4'd0;
      end else begin
        good_cnt_reg <= good_cnt_reg + 4'd1;
      end
    end
  end

  assign phase_err_o = phase_err_reg;
`endif

  assign vdata_o       = vdata_reg;
  assign vdata_valid_o = valid_reg;
  assign vinfo_o       = {frame_id_reg, pal_reg, interlaced_reg};

endmodule

// File: tb/tb_n64_vbus_demux.sv
// Directed testbench for n64_vbus_demux: pixel stream, resync, field info,
// line-counter saturation, PAL threshold and mid-pixel reset.
module tb_n64_vbus_demux;

  logic        VCLK = 1'b0;
  logic        nRST = 1'b0;
  logic        nDSYNC = 1'b1;
  logic [6:0]  D_i = 7'h00;
  logic [24:0] vdata_o;
  logic        vdata_valid_o;
  logic [2:0]  vinfo_o;
`ifdef VBUS_DEMUX_PHASE_ERR_EN
  logic        phase_err_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int first_strobe = -1;
  int prev_strobe = -1;
  int last_strobe = -1;
  logic [24:0] last_vd = '0;

  n64_vbus_demux dut (
    .VCLK          (VCLK),
    .nRST          (nRST),
    .nDSYNC        (nDSYNC),
    .D_i           (D_i),
    .vdata_o       (vdata_o),
    .vdata_valid_o (vdata_valid_o),
    .vinfo_o       (vinfo_o)
`ifdef VBUS_DEMUX_PHASE_ERR_EN
    ,
    .phase_err_o   (phase_err_o)
`endif
  );

  always #5 VCLK = ~VCLK;

  // Cycle counter (number of rising edges so far)
  always @(posedge VCLK) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge
  always @(negedge VCLK) begin
    if (vdata_valid_o) begin
      strobes     <= strobes + 1;
      prev_strobe <= last_strobe;
      last_strobe <= cyc;
      last_vd     <= vdata_o;
      if (first_strobe < 0) first_strobe <= cyc;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  // Drive one bus word on the falling edge
  task automatic put(input logic ds, input logic [6:0] d);
    @(negedge VCLK);
    nDSYNC = ds;
    D_i    = d;
  endtask

  task automatic pixel(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
    put(1'b0, {3'b000, s});
    put(1'b1, r);
    put(1'b1, g);
    put(1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b1, 7'h00);
  endtask

  // Sync word {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
  function automatic logic [6:0] sw(input logic v, input logic h);
    return {3'b000, v, 1'b1, h, v & h};
  endfunction

  // One line = one nHSYNC falling edge followed by its release
  task automatic line();
    put(1'b0, sw(1'b1, 1'b0));
    put(1'b0, sw(1'b1, 1'b1));
  endtask

  task automatic field(input int n, input logic hs_at_vs);
    repeat (n) line();
    put(1'b0, sw(1'b0, ~hs_at_vs));
    put(1'b0, sw(1'b1, 1'b1));
    idle(3);
  endtask

  // Watchdog: the run must never hang
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    int s0;

    // Reset state
    repeat (3) @(negedge VCLK);
    check_value("rst_vdata", 32'(vdata_o), 32'h1E00000);
    check_value("rst_valid", 32'(vdata_valid_o), 32'd0);
    check_value("rst_vinfo", 32'(vinfo_o), 32'd0);
    nRST = 1'b1;

    // Continuous stream F/12/34/56
    put(1'b0, 7'h0F); put(1'b1, 7'h12); put(1'b1, 7'h34); put(1'b1, 7'h56);
    b0 = cyc;
    pixel(4'hF, 7'h12, 7'h34, 7'h56);
    pixel(4'hF, 7'h12, 7'h34, 7'h56);
    idle(3);
    check_value("stream_count", 32'(strobes), 32'd3);
    check_value("stream_vdata", 32'(last_vd), {7'd0, 4'hF, 7'h12, 7'h34, 7'h56});
    check_value("first_strobe_lat", 32'(first_strobe), 32'(b0 + 2));
    check_value("strobe_period", 32'(last_strobe - prev_strobe), 32'd4);

    // Resync during G: broken pixel dropped, next one strobes
    s0 = strobes;
    put(1'b0, 7'h0F); put(1'b1, 7'h11);
    pixel(4'hE, 7'h21, 7'h22, 7'h23);
    idle(3);
    check_value("resync_count", 32'(strobes - s0), 32'd1);
    check_value("resync_vdata", 32'(last_vd), {7'd0, 4'hE, 7'h21, 7'h22, 7'h23});
`ifdef VBUS_DEMUX_PHASE_ERR_EN
    check_value("phase_err_set", 32'(phase_err_o), 32'd1);
    repeat (14) pixel(4'hF, 7'h01, 7'h02, 7'h03);
    idle(2);
    check_value("phase_err_15", 32'(phase_err_o), 32'd1);
    pixel(4'hF, 7'h01, 7'h02, 7'h03);
    idle(2);
    check_value("phase_err_clr", 32'(phase_err_o), 32'd0);
`endif

    // Progressive fields of 263 lines
    field(263, 1'b0);
    check_value("prog_field1", 32'(vinfo_o), 32'b000);
    field(263, 1'b0);
    check_value("prog_field2", 32'(vinfo_o), 32'b000);

    // Interlaced 312-line fields
    for (int k = 0; k < 4; k++) begin
      field(312, (k % 2) == 0);
      check_value($sformatf("ilace_field%0d", k), 32'(vinfo_o), ((k % 2) == 0) ? 32'b111 : 32'b011);
    end

    // Counter saturation
    repeat (1100) line();
    idle(2);
    check_value("lcnt_sat", 32'(dut.lcnt_reg), 32'd1023);
    field(0, 1'b0);
    check_value("sat_pal", 32'(vinfo_o), 32'b010);

    // PAL threshold boundary
    field(287, 1'b0);
    check_value("pal_287", 32'(vinfo_o), 32'b000);
    field(288, 1'b0);
    check_value("pal_288", 32'(vinfo_o), 32'b010);

    // Reset between R and G
    put(1'b0, 7'h0F); put(1'b1, 7'h33);
    @(negedge VCLK);
    nRST = 1'b0;
    #1;
    check_value("mid_rst_vdata", 32'(vdata_o), 32'h1E00000);
    check_value("mid_rst_valid", 32'(vdata_valid_o), 32'd0);
    check_value("mid_rst_vinfo", 32'(vinfo_o), 32'd0);
    s0 = strobes;
    @(negedge VCLK);
    nRST = 1'b1;
    put(1'b1, 7'h44); put(1'b1, 7'h55);
    idle(4);
    check_value("post_rst_nostrobe", 32'(strobes - s0), 32'd0);
    pixel(4'hF, 7'h01, 7'h02, 7'h03);
    idle(3);
    check_value("post_rst_strobe", 32'(strobes - s0), 32'd1);
    check_value("post_rst_vdata", 32'(last_vd), {7'd0, 4'hF, 7'h01, 7'h02, 7'h03});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
